// File: rtl/wyswietlacz_mux_if.sv
// Bundle between the RTC counting block and the 7-segment scan stage:
// the time digits and control strobes flow in, and the display drive
// flows out.
interface wyswietlacz_mux_if;
    logic       en_i;
    logic       sec_tick_i;
    logic [1:0] hr1_i;
    logic [3:0] hr2_i;
    logic [3:0] min1_i;
    logic [3:0] min2_i;
    logic [3:0] an_o;
    logic [6:0] seg_o;
    logic       dp_o;
    logic       frame_o;

    modport master (
        output en_i, sec_tick_i, hr1_i, hr2_i, min1_i, min2_i,
        input  an_o, seg_o, dp_o, frame_o
    );

    modport slave (
        input  en_i, sec_tick_i, hr1_i, hr2_i, min1_i, min2_i,
        output an_o, seg_o, dp_o, frame_o
    );
endinterface

// File: rtl/wyswietlacz_mux.sv
// 4-digit common-anode 7-segment scanner for the HH:MM real-time clock.
// All digits are snapshotted once per frame, at the start of the hr1 slot,
// so a carry that lands mid-scan cannot tear the displayed time.
// Each digit slot opens with a short all-dark window to prevent ghosting.
// The colon (dp_o) is shown on the hr2 digit and toggles on every second tick.
//
// Optional build macro: LEADING_ZERO_BLANK_EN
//   When it is defined, an hours-tens digit of 0 leaves the hr1 slot dark.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_BLANK | first BLANK_CYCLES of a slot: every anode is off
// ST_DRIVE | rest of the slot: the anode for idx is on and seg_o is decoded
module wyswietlacz_mux #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    wyswietlacz_mux_if.slave disp
);
    localparam int            CW      = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] C_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] C_BLANK = CW'(BLANK_CYCLES);
    localparam logic [6:0]    SEG_OFF = 7'h7F;
    localparam logic [6:0]    SEG_BAD = 7'b0111111;

    typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

    state_t        state_q;
    state_t        state_nxt;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_nxt;
    logic [1:0]    idx_q;
    logic [1:0]    idx_nxt;
    logic          colon_q;
    logic [1:0]    snap_hr1_q;
    logic [3:0]    snap_hr2_q;
    logic [3:0]    snap_min1_q;
    logic [3:0]    snap_min2_q;
    logic          snap_now;
    logic [3:0]    digit;
    logic [3:0]    digit_max;
    logic          lead_dark;
    logic [3:0]    an_q;
    logic [6:0]    seg_q;
    logic          dp_q;
    logic          frame_q;

    // Active-low decode. Anything above the largest legal value for its
    // position is shown as '-'.
    function automatic logic [6:0] decode(input logic [3:0] d, input logic [3:0] max_d);
        logic [6:0] s;
        s = SEG_BAD;
        if (d <= max_d) begin
            case (d)
                4'd0:    s = 7'b1000000;
                4'd1:    s = 7'b1111001;
                4'd2:    s = 7'b0100100;
                4'd3:    s = 7'b0110000;
                4'd4:    s = 7'b0011001;
                4'd5:    s = 7'b0010010;
                4'd6:    s = 7'b0000010;
                4'd7:    s = 7'b1111000;
                4'd8:    s = 7'b0000000;
                4'd9:    s = 7'b0010000;
                default: s = SEG_BAD;
            endcase
        end
        return s;
    endfunction

    // Next-slot position. Disabling the scan parks it at the start of a frame.
    always_comb begin
        cnt_nxt = cnt_q;
        idx_nxt = idx_q;
        if (!disp.en_i) begin
            cnt_nxt = '0;
            idx_nxt = 2'd3;
        end else if (cnt_q == C_LAST) begin
            cnt_nxt = '0;
            idx_nxt = idx_q - 2'd1;
        end else begin
            cnt_nxt = cnt_q + CW'(1);
        end
        state_nxt = (cnt_nxt < C_BLANK) ? ST_BLANK : ST_DRIVE;
    end

    assign snap_now = disp.en_i && (idx_q == 2'd3) && (cnt_q == '0);

    // Select the snapshotted digit for the current slot, together with its range limit.
    always_comb begin
        digit     = snap_min2_q;
        digit_max = 4'd9;
        case (idx_q)
            2'd3: begin
                digit     = {2'b00, snap_hr1_q};
                digit_max = 4'd2;
            end
            2'd2: begin
                digit     = snap_hr2_q;
                digit_max = 4'd9;
            end
            2'd1: begin
                digit     = snap_min1_q;
                digit_max = 4'd5;
            end
            default: begin
                digit     = snap_min2_q;
                digit_max = 4'd9;
            end
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        lead_dark = (idx_q == 2'd3) && (snap_hr1_q == 2'd0);
`else
        lead_dark = 1'b0;
`endif
    end

    // Scan FSM, frame snapshot, colon toggle and registered display drive.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_BLANK;
            cnt_q       <= '0;
            idx_q       <= 2'd3;
            colon_q     <= 1'b0;
            snap_hr1_q  <= '0;
            snap_hr2_q  <= '0;
            snap_min1_q <= '0;
            snap_min2_q <= '0;
            an_q        <= 4'b1111;
            seg_q       <= SEG_OFF;
            dp_q        <= 1'b1;
            frame_q     <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            idx_q   <= idx_nxt;
            frame_q <= snap_now;

            if (disp.sec_tick_i) begin
                colon_q <= ~colon_q;
            end

            if (snap_now) begin
                snap_hr1_q  <= disp.hr1_i;
                snap_hr2_q  <= disp.hr2_i;
                snap_min1_q <= disp.min1_i;
                snap_min2_q <= disp.min2_i;
            end

            an_q  <= 4'b1111;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
            if (disp.en_i) begin
                case (state_q)
                    ST_DRIVE: begin
                        if (!lead_dark) begin
                            an_q  <= ~(4'b0001 << idx_q);
                            seg_q <= decode(digit, digit_max);
                            dp_q  <= ~((idx_q == 2'd2) && colon_q);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign disp.an_o    = an_q;
    assign disp.seg_o   = seg_q;
    assign disp.dp_o    = dp_q;
    assign disp.frame_o = frame_q;
endmodule

// File: tb/tb_wyswietlacz_mux.sv
// Directed bench for the display scanner, run with REFRESH_DIV=8 and BLANK_CYCLES=2.
// Every frame is checked cycle by cycle against hand-derived expected drive values.
module tb_wyswietlacz_mux;
    localparam logic [6:0] S0   = 7'b1000000;
    localparam logic [6:0] S1   = 7'b1111001;
    localparam logic [6:0] S2   = 7'b0100100;
    localparam logic [6:0] S3   = 7'b0110000;
    localparam logic [6:0] S4   = 7'b0011001;
    localparam logic [6:0] S5   = 7'b0010010;
    localparam logic [6:0] SD   = 7'b0111111;
    localparam logic [12:0] DARK = {1'b0, 4'hF, 7'h7F, 1'b1};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_total = 0;
    int   n_bad   = 0;

    wyswietlacz_mux_if dif ();

    wyswietlacz_mux #(
        .REFRESH_DIV  (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .disp   (dif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [12:0] obs13();
        return {dif.frame_o, dif.an_o, dif.seg_o, dif.dp_o};
    endfunction

    task automatic set_time(input logic [13:0] t);
        dif.hr1_i  = t[13:12];
        dif.hr2_i  = t[11:8];
        dif.min1_i = t[7:4];
        dif.min2_i = t[3:0];
    endtask

    // Called on the negedge where frame_o is high. Checks 32 cycles and returns
    // on the negedge where the next frame starts. It can change the time inputs
    // at cycle poke_j and pulse sec_tick at cycle tick_j.
    task automatic run_frame(input string nm,
                             input logic [6:0] s3, input logic [6:0] s2,
                             input logic [6:0] s1, input logic [6:0] s0,
                             input logic blank3, input logic colon,
                             input int poke_j, input logic [13:0] poke_t,
                             input int tick_j);
        logic [6:0]  segs [4];
        logic [12:0] exp_v;
        int idx;
        int pos;
        segs[3] = s3;
        segs[2] = s2;
        segs[1] = s1;
        segs[0] = s0;
        for (int j = 0; j < 32; j++) begin
            idx = 3 - j / 8;
            pos = j % 8;
            if (pos < 2 || (idx == 3 && blank3)) begin
                exp_v = {(j == 0), 4'hF, 7'h7F, 1'b1};
            end else begin
                exp_v = {1'b0, 4'(~(4'b0001 << idx)), segs[idx], ~(idx == 2 && colon)};
            end
            chk($sformatf("%s_j%0d", nm, j), 16'(obs13()), 16'(exp_v));
            if (j == poke_j) set_time(poke_t);
            dif.sec_tick_i = (j == tick_j);
            @(negedge clk);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        dif.en_i       = 1'b0;
        dif.sec_tick_i = 1'b0;
        set_time({2'd1, 4'd2, 4'd3, 4'd4});
        repeat (2) @(negedge clk);
        chk("reset_dark", 16'(obs13()), 16'(DARK));

        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("en_low_dark", 16'(obs13()), 16'(DARK));

        dif.en_i = 1'b1;
        @(negedge clk);
        chk("first_frame", 16'(dif.frame_o), 16'(1'b1));

        run_frame("f_1234", S1, S2, S3, S4, 1'b0, 1'b0, -1, '0, -1);
        run_frame("f_poke", S1, S2, S3, S4, 1'b0, 1'b0, 12, {2'd1, 4'd2, 4'd3, 4'd5}, -1);
        run_frame("f_1235", S1, S2, S3, S5, 1'b0, 1'b0, 20, {2'd3, 4'd2, 4'hC, 4'd5}, -1);
        run_frame("f_dash", SD, S2, SD, S5, 1'b0, 1'b0, 20, {2'd1, 4'd2, 4'd3, 4'd5}, 30);
        run_frame("f_colon", S1, S2, S3, S5, 1'b0, 1'b1, 20, {2'd0, 4'd5, 4'd0, 4'd0}, 30);
        run_frame("f_0500", S0, S5, S0, S0, LZ, 1'b0, -1, '0, -1);

        repeat (10) @(negedge clk);
        chk("pre_rst_drive", 16'(dif.an_o), 16'(4'b1011));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_dark", 16'(obs13()), 16'(DARK));
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_no_frame", 16'(dif.frame_o), 16'(1'b0));
        @(negedge clk);
        chk("rst_frame", 16'(dif.frame_o), 16'(1'b1));
        run_frame("f_post_rst", S0, S5, S0, S0, LZ, 1'b0, -1, '0, -1);

        repeat (12) @(negedge clk);
        dif.en_i = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("en_off_%0d", k), 16'(obs13()), 16'(DARK));
        end
        dif.en_i = 1'b1;
        @(negedge clk);
        chk("en_on_frame", 16'(dif.frame_o), 16'(1'b1));
        run_frame("f_en_on", S0, S5, S0, S0, LZ, 1'b0, -1, '0, -1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
